// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler feeding the UART transmitter from two byte requesters.
// Tracks frame and gap length in b_tick units so a new frame never overlaps one still on the line.
module uart_tx_sched #(
    parameter int TICKS_PER_BIT = 16,
    parameter int GAP_BITS      = 0,
    parameter int ACK_TIMEOUT   = 8
) (
    input  logic       clk,
    input  logic       a_resetn,
    input  logic       b_tick,
    input  logic       cfg_enable,
    input  logic [1:0] cfg_parity,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_d_in,
    output logic [1:0] tx_parity,
    input  logic       tx_get_data,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done,
    output logic       ack_err
);
    typedef enum logic [1:0] {IDLE, START, FRAME, GAP} state_t;

    localparam logic [11:0] T10      = 12'(TICKS_PER_BIT * 10);
    localparam logic [11:0] T11      = 12'(TICKS_PER_BIT * 11);
    localparam logic [11:0] GAP_LAST = 12'(GAP_BITS * TICKS_PER_BIT - 1);
    localparam logic [11:0] ACK_LAST = 12'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [11:0] cnt_q;
    logic        rr_q;
    logic        req0_ready_q, req1_ready_q, tx_start_q, grant_q, frame_done_q, ack_err_q;
    logic [7:0]  tx_d_in_q;
    logic [1:0]  tx_parity_q;
    logic        gnt_d, gnt_id_d;
    logic [1:0]  parity_d;
    logic [11:0] frame_last;

    // With both requesters valid, the one that did not win last time gets the grant.
    always_comb begin
        gnt_d      = cfg_enable && (req0_valid || req1_valid);
        gnt_id_d   = (req0_valid && req1_valid) ? ~rr_q : req1_valid;
        parity_d   = (cfg_parity == 2'b11) ? 2'b00 : cfg_parity;
        frame_last = ((tx_parity_q != 2'b00) ? T11 : T10) - 12'd1;
    end

    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_q         <= 1'b1;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_d_in_q    <= '0;
            tx_parity_q  <= '0;
            grant_q      <= 1'b0;
            frame_done_q <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            frame_done_q <= 1'b0;
            ack_err_q    <= 1'b0;
            case (state_q)
                IDLE: if (gnt_d) begin
                    req0_ready_q <= ~gnt_id_d;
                    req1_ready_q <= gnt_id_d;
                    tx_d_in_q    <= gnt_id_d ? req1_data : req0_data;
                    tx_parity_q  <= parity_d;
                    grant_q      <= gnt_id_d;
                    rr_q         <= gnt_id_d;
                    tx_start_q   <= 1'b1;
                    cnt_q        <= '0;
                    state_q      <= START;
                end
                START: if (tx_get_data) begin
                    tx_start_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= FRAME;
                end else if (cnt_q == ACK_LAST) begin
                    tx_start_q <= 1'b0;
                    ack_err_q  <= 1'b1;
                    state_q    <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 12'd1;
                end
                FRAME: if (b_tick) begin
                    if (cnt_q == frame_last) begin
                        cnt_q <= '0;
                        if (GAP_BITS > 0) begin
                            state_q <= GAP;
                        end else begin
                            frame_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end
                GAP: if (b_tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q        <= '0;
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end
            endcase
        end
    end

    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;
    assign tx_start   = tx_start_q;
    assign tx_d_in    = tx_d_in_q;
    assign tx_parity  = tx_parity_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign frame_done = frame_done_q;
    assign ack_err    = ack_err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized checks of uart_tx_sched against a frame-level model
// (round-robin owner, byte, parity and b_tick count per frame), plus a GAP_BITS=2 instance.
module tb_uart_tx_sched;
    logic       clk = 1'b0;
    logic       a_resetn, b_tick, cfg_enable, req0_valid, req1_valid, tx_get_data;
    logic [1:0] cfg_parity;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, tx_start, busy, grant_id, frame_done, ack_err;
    logic [7:0] tx_d_in;
    logic [1:0] tx_parity;
    logic       g_req0_ready, g_req1_ready, g_tx_start, g_busy, g_grant_id, g_frame_done, g_ack_err;
    logic [7:0] g_tx_d_in;
    logic [1:0] g_tx_parity;

    int checks = 0, errors = 0, cyc = 0;
    int start_age, starts, r0, r1, errs_seen, ticks, done_ticks, g_done_ticks;
    logic ack_en, acked, done, g_done, last;

    always #5 clk = ~clk;

    uart_tx_sched dut (
        .clk(clk), .a_resetn(a_resetn), .b_tick(b_tick), .cfg_enable(cfg_enable),
        .cfg_parity(cfg_parity), .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_ready(req0_ready), .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_ready(req1_ready), .tx_start(tx_start), .tx_d_in(tx_d_in),
        .tx_parity(tx_parity), .tx_get_data(tx_get_data), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done), .ack_err(ack_err)
    );

    uart_tx_sched #(.GAP_BITS(2)) dut_gap (
        .clk(clk), .a_resetn(a_resetn), .b_tick(b_tick), .cfg_enable(cfg_enable),
        .cfg_parity(cfg_parity), .req0_valid(req0_valid), .req0_data(req0_data),
        .req0_ready(g_req0_ready), .req1_valid(req1_valid), .req1_data(req1_data),
        .req1_ready(g_req1_ready), .tx_start(g_tx_start), .tx_d_in(g_tx_d_in),
        .tx_parity(g_tx_parity), .tx_get_data(tx_get_data), .busy(g_busy),
        .grant_id(g_grant_id), .frame_done(g_frame_done), .ack_err(g_ack_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then play transmitter and baud source.
    task automatic step();
        @(negedge clk);
        cyc++;
        start_age = tx_start ? start_age + 1 : 0;
        if (tx_start) starts++;
        if (req0_ready) r0++;
        if (req1_ready) r1++;
        if (ack_err) errs_seen++;
        if (frame_done && !done) begin done = 1'b1; done_ticks = ticks; end
        if (g_frame_done && !g_done) begin g_done = 1'b1; g_done_ticks = ticks; end
        b_tick = (cyc % 4 == 0);
        if (b_tick && acked) ticks++;
        tx_get_data = ack_en && (start_age == 2);
        if (tx_get_data) begin acked = 1'b1; ticks = 0; end
    endtask

    task automatic clear();
        done = 1'b0; g_done = 1'b0; acked = 1'b0; ticks = 0; starts = 0;
        r0 = 0; r1 = 0; errs_seen = 0; done_ticks = -1; g_done_ticks = -1;
    endtask

    task automatic do_reset();
        a_resetn = 1'b0;
        step();
        step();
        a_resetn = 1'b1;
        last = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic eid, input logic [7:0] ed,
                             input logic [1:0] ep, input int et, input logic refresh,
                             input logic drop_en);
        logic seen = 1'b0;
        clear();
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            if ((req0_ready || req1_ready) && !seen) begin
                seen = 1'b1;
                chk({tag, "_id"}, grant_id, eid);
                chk({tag, "_rdy"}, req1_ready, eid);
                chk({tag, "_data"}, tx_d_in, ed);
                chk({tag, "_par"}, tx_parity, ep);
                chk({tag, "_start"}, tx_start, 1);
                if (refresh) begin
                    if (req0_ready) req0_data = 8'($urandom);
                    else req1_data = 8'($urandom);
                end
                if (drop_en) cfg_enable = 1'b0;
            end
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ticks"}, done_ticks, et);
        chk({tag, "_nstart"}, starts, 2);
        chk({tag, "_nrdy"}, {r0[15:0], r1[15:0]}, eid ? 32'h0000_0001 : 32'h0001_0000);
        chk({tag, "_busy"}, busy, 0);
    endtask

    function automatic int frame_ticks(input logic [1:0] p);
        return 16 * ((p == 2'b01 || p == 2'b10) ? 11 : 10);
    endfunction

    initial begin
        logic eid;
        logic [1:0] ep;
        int r;
        a_resetn = 1'b0; b_tick = 1'b0; cfg_enable = 1'b1; cfg_parity = 2'b00;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
        tx_get_data = 1'b0; ack_en = 1'b1; start_age = 0;
        clear();
        do_reset();
        chk("reset_out", {req0_ready, req1_ready, tx_start, tx_d_in, tx_parity, busy,
                          grant_id, frame_done, ack_err}, 0);

        // Gap instance: requester drops after one accept so both instances see a single frame.
        clear();
        req0_data = 8'h3C; req0_valid = 1'b1;
        for (int i = 0; i < 10 && r0 == 0; i++) step();
        req0_valid = 1'b0;
        chk("gap_data", g_tx_d_in, 8'h3C);
        for (int i = 0; i < 2000 && !g_done; i++) step();
        chk("gap_nogap_ticks", done_ticks, 160);
        chk("gap_ticks", g_done_ticks, 192);
        chk("gap_busy", g_busy, 0);

        req0_data = 8'hA5; req0_valid = 1'b1;
        run_frame("t1", 1'b0, 8'hA5, 2'b00, 160, 1'b0, 1'b0);

        do_reset();
        req0_data = 8'h11; req1_data = 8'h22; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            eid = ~last;
            run_frame("rr", eid, eid ? 8'h22 : 8'h11, 2'b00, 160, 1'b0, 1'b0);
            last = eid;
        end

        req1_valid = 1'b0; cfg_parity = 2'b01;
        run_frame("par01", 1'b0, 8'h11, 2'b01, 176, 1'b0, 1'b0);
        cfg_parity = 2'b11;
        run_frame("par11", 1'b0, 8'h11, 2'b00, 160, 1'b0, 1'b0);
        last = 1'b0;

        // Transmitter never acknowledges: frame aborted, then the same requester is re-granted.
        ack_en = 1'b0; cfg_parity = 2'b00;
        clear();
        for (int i = 0; i < 50 && errs_seen == 0; i++) step();
        chk("to_err", errs_seen, 1);
        chk("to_nstart", starts, 8);
        chk("to_busy", busy, 0);
        chk("to_start", tx_start, 0);
        ack_en = 1'b1;
        run_frame("to_regrant", 1'b0, 8'h11, 2'b00, 160, 1'b0, 1'b0);

        run_frame("en_drop", 1'b0, 8'h11, 2'b00, 160, 1'b0, 1'b1);
        clear();
        for (int i = 0; i < 30; i++) step();
        chk("en_off_rdy", r0 + r1, 0);
        chk("en_off_busy", busy, 0);
        cfg_enable = 1'b1;
        run_frame("en_on", 1'b0, 8'h11, 2'b00, 160, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            r = $urandom_range(1, 3);
            req0_valid = r[0]; req1_valid = r[1];
            cfg_parity = 2'($urandom);
            eid = (req0_valid && req1_valid) ? ~last : req1_valid;
            ep = (cfg_parity == 2'b11) ? 2'b00 : cfg_parity;
            run_frame("rand", eid, eid ? req1_data : req0_data, ep, frame_ticks(ep), 1'b1, 1'b0);
            last = eid;
        end

        // Asynchronous reset in the middle of a frame.
        req0_valid = 1'b1; req1_valid = 1'b0; req0_data = 8'hA5; cfg_parity = 2'b10;
        clear();
        for (int i = 0; i < 10 && r0 == 0; i++) step();
        for (int i = 0; i < 100; i++) step();
        chk("mid_busy", busy, 1);
        a_resetn = 1'b0;
        #1;
        chk("mid_rst_out", {req0_ready, req1_ready, tx_start, tx_d_in, tx_parity, busy,
                            grant_id, frame_done, ack_err}, 0);
        step();
        a_resetn = 1'b1;
        last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'h5A; cfg_parity = 2'b00;
        run_frame("post_rst", 1'b0, 8'hA5, 2'b00, 160, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Transmit scheduler in front of the UART transmitter. It arbitrates round-robin between two byte requesters: the TX FIFO drain (req0) and the AXI-Lite direct-write path (req1). It drives the transmitter's start/data/parity inputs and completes the tx_get_data handshake. It tracks frame duration by counting b_tick, so a new frame is never issued while one is still on the line.

Parameters:
TICKS_PER_BIT, 16, b_tick pulses per serial bit (must match transmitter oversampling)
GAP_BITS, 0, idle bit-times inserted after each stop bit before next grant (0..15)
ACK_TIMEOUT, 8, clk cycles to wait for tx_get_data after tx_start before aborting (>=2)

Ports:
clk  in  1  clock
a_resetn  in  1  asynchronous active-low reset
b_tick  in  1  baud oversample tick, same tick as transmitter
cfg_enable  in  1  1 = grants allowed
cfg_parity  in  2  00 none, 01 odd, 10 even, 11 treated as none
req0_valid  in  1  FIFO byte available
req0_data  in  8  FIFO byte
req0_ready  out  1  one-cycle accept pulse to FIFO
req1_valid  in  1  direct-write byte available
req1_data  in  8  direct-write byte
req1_ready  out  1  one-cycle accept pulse to direct path
tx_start  out  1  to transmitter tx_start
tx_d_in  out  8  to transmitter d_in
tx_parity  out  2  to transmitter parity
tx_get_data  in  1  transmitter accept pulse
busy  out  1  1 in any state except IDLE
grant_id  out  1  requester owning current/last frame
frame_done  out  1  one-cycle pulse at end of frame+gap
ack_err  out  1  one-cycle pulse on ACK_TIMEOUT expiry

Behaviour:
- Clock and reset: clk; reset a_resetn, asynchronous, active-low. Mid-operation reset returns to IDLE immediately.
- Reset values: all outputs 0, state IDLE, RR pointer = 1, so req0 has first priority.
- States: IDLE, START, FRAME, GAP.
- IDLE:
  - If cfg_enable=1 and any valid, grant. With one valid, grant it. With both valid, grant the one not equal to the RR pointer.
  - Same cycle: assert reqN_ready for exactly one cycle. Register data into tx_d_in; register parity into tx_parity (11 -> 00).
  - Set grant_id and RR pointer = N; go to START.
  - No grant while cfg_enable=0. A valid that drops before grant is ignored.
- START:
  - tx_start=1; count clk cycles.
  - On tx_get_data=1: tx_start=0 on the next edge, clear tick counter, go to FRAME. tx_start is high for no cycle after the one in which tx_get_data is sampled high.
  - If the count reaches ACK_TIMEOUT with no tx_get_data: tx_start=0, ack_err pulse, byte dropped, go to IDLE.
- FRAME:
  - Count b_tick. Target = TICKS_PER_BIT*(10 + (tx_parity!=0)), i.e. 160 or 176 at default.
  - When the count reaches the target: go to GAP if GAP_BITS>0, else pulse frame_done and go to IDLE.
  - Counter width 12 bits.
- GAP: count GAP_BITS*TICKS_PER_BIT b_ticks, then pulse frame_done and go to IDLE.
- tx_d_in and tx_parity hold stable from grant until the next grant. The transmitter re-samples d_in during its start bit.
- cfg_parity or cfg_enable changes during a frame affect only later grants.
- Latency: valid to tx_start is 1 cycle; tx_start to get_data is normally 1 cycle.
- frame_done to next reqN_ready is at least 1 cycle (IDLE evaluation).
- b_tick outside FRAME/GAP is ignored.

Test Plan:
1. req0_valid=1, data 0xA5, parity 00, b_tick every 4 clk; transmitter model acks 1 cycle after start -> req0_ready 1 cycle, tx_d_in=0xA5, tx_start high 2 cycles, frame_done after exactly 160 b_ticks, busy low next cycle.
2. Both valid continuously, req0=0x11, req1=0x22 -> grants alternate 0,1,0,1 starting with req0; tx_d_in sequence 0x11,0x22,0x11,0x22.
3. cfg_parity=01 -> tx_parity=01, frame_done after 176 b_ticks. Repeat with cfg_parity=11 -> tx_parity=00, 160 b_ticks.
4. Transmitter model never acks -> tx_start high 8 cycles, ack_err pulse, back to IDLE, next valid re-granted normally.
5. GAP_BITS=2 -> frame_done after 160+32 b_ticks. Toggling cfg_enable=0 mid-frame -> frame completes, no further grant until enable=1.
6. Assert a_resetn=0 during FRAME -> all outputs 0 asynchronously. After release, req0 gets first priority.
